conv3x3_mac: RTL and testbench

- Stage directly downstream of the 3x3 window address sequencer and image SRAM.
- Consumes the 9-tap pixel stream (row-major, top-left first), one tap per cycle.
- Multiplies each tap by a programmable signed 3x3 kernel coefficient and accumulates the products.
- Emits one shifted, saturated 16-bit filtered pixel per window and counts outputs to flag end of frame.

---
 rtl/conv3x3_mac.sv | 192 +++++++++++++++++++
 tb/tb_conv3x3_mac.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac.sv
// conv3x3_mac
// 3x3 convolution multiply-accumulate stage. Consumes a 9-tap pixel stream
// (row-major, top-left first), multiplies each tap by a programmable signed
// kernel coefficient, and emits one shifted, saturated 16-bit pixel per window.
// It also counts outputs so that it can flag the end of each frame.
//
// Tap stream handshake: the stream is valid-only. A tap is transferred on
// every rising edge where pix_valid=1. There is no ready; the upstream
// sequencer cannot be stalled, so this stage accepts or drops every valid tap
// in the cycle it is presented. pix_first is meaningful only with pix_valid
// and marks tap 0 of a window.
//
// The output side is a one-cycle out_valid pulse with no backpressure. out_pix
// holds its last value between pulses.
//
// dbg_state exposes the FSM state (0=IDLE, 1=ACCUM, 2=EMIT) for checkers.
module conv3x3_mac #(
   parameter int COEF_W       = 8,
   parameter int SHIFT        = 0,
   parameter int FRAME_PIXELS = 260100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       pix_in,
   input  logic              pix_valid,
   input  logic              pix_first,
   input  logic              coef_we,
   input  logic [3:0]        coef_addr,
   input  logic [COEF_W-1:0] coef_din,
   output logic [15:0]       out_pix,
   output logic              out_valid,
   output logic [17:0]       out_count,
   output logic              frame_done,
   output logic              seq_err,
   output logic [1:0]        dbg_state
);

   localparam int ACC_W  = 29;
   localparam int PROD_W = COEF_W + 17;
   localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(65535);
   localparam logic        [17:0]      FRAME_CNT = 18'(FRAME_PIXELS);
   localparam logic        [3:0]       LAST_TAP  = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_EMIT  = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic        [3:0]         tap_q, tap_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic                      seq_err_d;
   logic                      fire;

   logic signed [COEF_W-1:0]  coef_q [9];
   logic        [3:0]         tap_sel;
   logic signed [COEF_W-1:0]  coef_sel;
   logic signed [16:0]        pix_s;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   sum_full;
   logic signed [ACC_W-1:0]   shifted;
   logic        [15:0]        sat_pix;
   logic        [17:0]        count_inc;

   // Coefficient bank: identity kernel on reset; out-of-range addresses ignored.
   // A write lands at the edge, so a tap sampled on that edge still sees the old value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 9; i++) begin
            coef_q[i] <= (i == 4) ? COEF_W'(1) : '0;
         end
      end else if (coef_we && (coef_addr <= LAST_TAP)) begin
         coef_q[coef_addr] <= coef_din;
      end
   end

   // Datapath: pick this tap's coefficient, form the signed product and the running sum.
   always_comb begin
      tap_sel  = pix_first ? 4'd0 : tap_q;
      coef_sel = (tap_sel <= LAST_TAP) ? coef_q[tap_sel] : '0;
      pix_s    = $signed({1'b0, pix_in});
      prod     = PROD_W'(pix_s) * PROD_W'(coef_sel);
      prod_ext = ACC_W'(prod);
      sum_full = acc_q + prod_ext;
   end

   // Shift and clamp the completed window sum into the unsigned 16-bit range.
   always_comb begin
      shifted = sum_full >>> SHIFT;
      if (shifted[ACC_W-1]) begin
         sat_pix = 16'h0000;
      end else if (shifted > SAT_MAX) begin
         sat_pix = 16'hFFFF;
      end else begin
         sat_pix = shifted[15:0];
      end
      count_inc = out_count + 18'd1;
   end

   // FSM state, tap index, accumulator and sticky sequencing error register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         tap_q   <= 4'd0;
         acc_q   <= '0;
         seq_err <= 1'b0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         acc_q   <= acc_d;
         seq_err <= seq_err_d;
      end
   end

   // FSM next state: tap acceptance, window restart on an early pix_first, and emit trigger.
   always_comb begin
      state_d   = state_q;
      tap_d     = tap_q;
      acc_d     = acc_q;
      seq_err_d = seq_err;
      fire      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pix_valid && pix_first) begin
               acc_d   = prod_ext;
               tap_d   = 4'd1;
               state_d = ST_ACCUM;
            end else if (pix_valid) begin
               seq_err_d = 1'b1;
            end
         end
         ST_ACCUM: begin
            if (pix_valid && pix_first) begin
               // Early tap 0: drop the partial window and restart from this tap.
               seq_err_d = 1'b1;
               acc_d     = prod_ext;
               tap_d     = 4'd1;
            end else if (pix_valid) begin
               acc_d = sum_full;
               if (tap_q == LAST_TAP) begin
                  tap_d   = 4'd0;
                  state_d = ST_EMIT;
                  fire    = 1'b1;
               end else begin
                  tap_d = tap_q + 4'd1;
               end
            end
         end
         ST_EMIT: begin
            state_d = ST_IDLE;
            tap_d   = 4'd0;
            if (pix_valid && pix_first) begin
               // Back-to-back window: tap 0 arrives while the result is on the output.
               acc_d   = prod_ext;
               tap_d   = 4'd1;
               state_d = ST_ACCUM;
            end else if (pix_valid) begin
               seq_err_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tap_d   = 4'd0;
         end
      endcase
   end

   // Output registers: the result is registered as tap 8 is accepted, so the
   // pulse is visible during the EMIT cycle. The frame count wraps one edge later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_pix    <= 16'h0000;
         out_valid  <= 1'b0;
         out_count  <= 18'd0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= fire;
         frame_done <= fire && (count_inc == FRAME_CNT);
         if (fire) begin
            out_pix   <= sat_pix;
            out_count <= count_inc;
         end else if (frame_done) begin
            out_count <= 18'd0;
         end
      end
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac
// Bench for conv3x3_mac with a 4-output frame. Expected pixels come from a
// small integer model of the kernel and go into a queue as each window is
// driven. A negedge monitor pops and compares them on every out_valid pulse.
module tb_conv3x3_mac;

   localparam int SHIFT = 0;
   localparam int FRAME = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pix_in;
   logic        pix_valid;
   logic        pix_first;
   logic        coef_we;
   logic [3:0]  coef_addr;
   logic [7:0]  coef_din;
   logic [15:0] out_pix;
   logic        out_valid;
   logic [17:0] out_count;
   logic        frame_done;
   logic        seq_err;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] exp_q[$];
   int kmodel [9];
   int win_pix [9];
   int exp_cnt = 0;

   conv3x3_mac #(
      .COEF_W(8),
      .SHIFT(SHIFT),
      .FRAME_PIXELS(FRAME)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pix_in(pix_in),
      .pix_valid(pix_valid),
      .pix_first(pix_first),
      .coef_we(coef_we),
      .coef_addr(coef_addr),
      .coef_din(coef_din),
      .out_pix(out_pix),
      .out_valid(out_valid),
      .out_count(out_count),
      .frame_done(frame_done),
      .seq_err(seq_err),
      .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_pix();
      int s;
      s = 0;
      for (int i = 0; i < 9; i++) s += win_pix[i] * kmodel[i];
      s = s >>> SHIFT;
      if (s < 0) return 16'h0000;
      if (s > 65535) return 16'hFFFF;
      return 16'(s);
   endfunction

   // driver tasks
   task automatic drive_tap(input logic [15:0] v, input logic f);
      pix_in    = v;
      pix_valid = 1'b1;
      pix_first = f;
      @(posedge clk); #1;
      pix_valid = 1'b0;
      pix_first = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic write_coef(input int a, input int v);
      coef_we   = 1'b1;
      coef_addr = 4'(a);
      coef_din  = 8'(v);
      if (a >= 0 && a <= 8) kmodel[a] = int'($signed(coef_din));
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   task automatic set_kernel(input int center, input int others);
      for (int i = 0; i < 9; i++) write_coef(i, (i == 4) ? center : others);
   endtask

   task automatic drive_window();
      exp_q.push_back(model_pix());
      for (int i = 0; i < 9; i++) drive_tap(16'(win_pix[i]), i == 0);
      check("latency", {31'd0, out_valid}, 32'd1);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         exp_cnt = 0;
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", {31'd0, out_valid}, 32'd0);
         end else begin
            check("out_pix", {16'd0, out_pix}, {16'd0, exp_q.pop_front()});
         end
         exp_cnt++;
         check("out_count", {14'd0, out_count}, exp_cnt);
         check("frame_done", {31'd0, frame_done}, (exp_cnt == FRAME) ? 32'd1 : 32'd0);
         if (exp_cnt == FRAME) exp_cnt = 0;
      end else begin
         check("frame_done_idle", {31'd0, frame_done}, 32'd0);
         check("out_count_hold", {14'd0, out_count}, exp_cnt);
      end
   end

   // stimulus
   initial begin
      rst = 1'b0; pix_in = '0; pix_valid = 1'b0; pix_first = 1'b0;
      coef_we = 1'b0; coef_addr = '0; coef_din = '0;
      for (int i = 0; i < 9; i++) kmodel[i] = (i == 4) ? 1 : 0;
      #12;
      check("rst_out_pix", {16'd0, out_pix}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_count", {14'd0, out_count}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_seq_err", {31'd0, seq_err}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      idle(2);

      // identity kernel straight out of reset
      for (int i = 0; i < 9; i++) win_pix[i] = 10 * (i + 1);
      drive_window();
      idle(3);
      check("hold_pix", {16'd0, out_pix}, 32'd50);

      // all-ones kernel: plain sum and high saturation
      set_kernel(1, 1);
      for (int i = 0; i < 9; i++) win_pix[i] = 16'h1000;
      drive_window();
      idle(1);
      for (int i = 0; i < 9; i++) win_pix[i] = 16'hFFFF;
      drive_window();
      idle(1);

      // Laplacian: negative clamp, then a positive result (4th output ends the frame)
      set_kernel(8, -1);
      for (int i = 0; i < 9; i++) win_pix[i] = (i == 4) ? 0 : 100;
      drive_window();
      idle(1);
      for (int i = 0; i < 9; i++) win_pix[i] = (i == 4) ? 200 : 0;
      drive_window();
      idle(1);

      // coefficient written in the same cycle as its tap: old value applies
      set_kernel(1, 1);
      exp_q.push_back(16'd900);
      for (int i = 0; i < 9; i++) begin
         if (i == 4) begin
            coef_we = 1'b1; coef_addr = 4'd4; coef_din = 8'd5;
         end
         drive_tap(16'd100, i == 0);
         coef_we = 1'b0;
      end
      kmodel[4] = 5;
      check("latency", {31'd0, out_valid}, 32'd1);
      idle(1);
      for (int i = 0; i < 9; i++) win_pix[i] = 100;
      drive_window();
      idle(1);

      // random kernel, 10-cycle cadence
      for (int i = 0; i < 9; i++) write_coef(i, int'($urandom_range(0, 39)) - 8);
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < 9; i++) win_pix[i] = int'($urandom_range(0, 4095));
         drive_window();
         idle(1);
      end
      check("seq_err_cad10", {31'd0, seq_err}, 32'd0);

      // 9-cycle cadence: tap 0 lands in the EMIT cycle
      for (int w = 0; w < 4; w++) begin
         for (int i = 0; i < 9; i++) win_pix[i] = int'($urandom_range(0, 4095));
         drive_window();
      end
      idle(2);
      check("seq_err_cad9", {31'd0, seq_err}, 32'd0);

      // stray tap, aborted window, out-of-range coefficient writes ignored
      set_kernel(1, 1);
      write_coef(9, 8'h55);
      write_coef(15, 8'h33);
      drive_tap(16'd777, 1'b0);
      idle(1);
      check("seq_err_stray", {31'd0, seq_err}, 32'd1);
      check("state_after_stray", {30'd0, dbg_state}, 32'd0);
      for (int i = 0; i < 5; i++) drive_tap(16'd500, i == 0);
      for (int i = 0; i < 9; i++) win_pix[i] = i + 1;
      drive_window();
      idle(1);
      drive_window();
      idle(2);
      check("seq_err_sticky", {31'd0, seq_err}, 32'd1);
      check("hold_pix2", {16'd0, out_pix}, 32'd45);

      // asynchronous reset in the middle of a window
      write_coef(4, 3);
      for (int i = 0; i < 3; i++) drive_tap(16'd1234, i == 0);
      rst = 1'b0;
      #2;
      check("arst_out_pix", {16'd0, out_pix}, 32'd0);
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_out_count", {14'd0, out_count}, 32'd0);
      check("arst_frame_done", {31'd0, frame_done}, 32'd0);
      check("arst_seq_err", {31'd0, seq_err}, 32'd0);
      check("arst_state", {30'd0, dbg_state}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      idle(1);
      for (int i = 0; i < 9; i++) kmodel[i] = (i == 4) ? 1 : 0;
      for (int i = 0; i < 9; i++) win_pix[i] = 10 * (i + 1);
      drive_window();
      idle(3);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
